// File: rtl/tx_arb_pkg.sv
// Shared definitions for the byte transmit arbiter.
//   arb_state_e     : FSM encoding (IDLE, SETUP, SEND, DONE)
//   DEFAULT_NREQ    : default number of requesters
//   DEFAULT_TIMEOUT : default cycle limit for load held high per transfer
//   TIMER_W         : width of the SEND-phase cycle timer
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_TIMEOUT = 200;
  localparam int TIMER_W         = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at lastGrant+1 (modulo NREQ) and returns the first
// requester found.
//   req       : request vector
//   lastGrant : index of the most recently served requester
//   grant     : selected requester index (0 when valid is low)
//   valid     : at least one request is pending
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter  int NREQ = DEFAULT_NREQ,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] lastGrant,
  output logic [IDXW-1:0] grant,
  output logic            valid
);

  int cand_s;

  // Priority search over the rotated request vector; the first hit wins.
  always_comb begin
    grant  = '0;
    valid  = 1'b0;
    cand_s = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(lastGrant) + k) % NREQ;
      if (!valid && req[cand_s]) begin
        grant = IDXW'(cand_s);
        valid = 1'b1;
      end else begin
        // an earlier candidate already won, or this one is idle
      end
    end
  end

endmodule

// File: rtl/byte_tx_arbiter.sv
// Byte transmit arbiter: grants one of NREQ requesters round-robin, presents
// its byte to a serial shifter, holds load high until the shifter reports
// txDone (or TIMEOUT cycles pass), then acks the requester.
//   clk, rst  : clock, synchronous active-high reset
//   req, data : per-requester request and byte (requester i at [8i+7:8i])
//   ack       : one-cycle completion pulse to the served requester
//   load      : shifter load strobe, byteOut : shifter byte
//   txDone    : shifter completion pulse (only honoured in SEND)
//   busy      : high outside IDLE
//   errPulse  : one-cycle timeout pulse, errFlag : sticky timeout flag
module byte_tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter  int NREQ    = DEFAULT_NREQ,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              load,
  output logic [7:0]        byteOut,
  input  logic              txDone,
  output logic              busy,
  output logic              errPulse,
  output logic              errFlag
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [IDXW-1:0]    GRANT_INIT = IDXW'(NREQ - 1);

  arb_state_e         state_r;
  logic [TIMER_W-1:0] timer_r;
  logic [IDXW-1:0]    grant_r;
  logic [IDXW-1:0]    last_grant_r;
  logic [IDXW-1:0]    pick_s;
  logic               pick_valid_s;
  logic [7:0]         pick_byte_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (req),
    .lastGrant (last_grant_r),
    .grant     (pick_s),
    .valid     (pick_valid_s)
  );

  // Byte lane of the requester the picker currently selects.
  assign pick_byte_s = data[{pick_s, 3'b000} +: 8];

  // Transfer FSM with timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      grant_r      <= '0;
      last_grant_r <= GRANT_INIT;
      ack          <= '0;
      load         <= 1'b0;
      byteOut      <= 8'h00;
      busy         <= 1'b0;
      errPulse     <= 1'b0;
      errFlag      <= 1'b0;
    end else begin
      // ack and errPulse are single-cycle pulses unless set below
      ack      <= '0;
      errPulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_r <= pick_s;
            byteOut <= pick_byte_s;
            busy    <= 1'b1;
            state_r <= ST_SETUP;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          load    <= 1'b1;
          timer_r <= '0;
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          // txDone is checked first so it wins over a simultaneous timeout
          if (txDone) begin
            load          <= 1'b0;
            ack[grant_r]  <= 1'b1;
            last_grant_r  <= grant_r;
            state_r       <= ST_DONE;
          end else if (timer_r == TIMER_LAST) begin
            load          <= 1'b0;
            ack[grant_r]  <= 1'b1;
            last_grant_r  <= grant_r;
            errPulse      <= 1'b1;
            errFlag       <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          load    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_tx_arbiter.sv
// Directed self-checking bench for byte_tx_arbiter (NREQ=4, TIMEOUT=20).
module tb_byte_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] data = {8'h44, 8'h33, 8'h22, 8'h0B};
  logic [NREQ-1:0]   ack;
  logic              load;
  logic [7:0]        byteOut;
  logic              txDone = 1'b0;
  logic              busy;
  logic              errPulse;
  logic              errFlag;

  int checks = 0;
  int errors = 0;

  byte_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .load     (load),
    .byteOut  (byteOut),
    .txDone   (txDone),
    .busy     (busy),
    .errPulse (errPulse),
    .errFlag  (errFlag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req    = '0;
    txDone = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives one transfer from IDLE: waits for load, plays the shifter
  // (txDone on load-high cycle done_at, 0 = never), and reports what it saw.
  task automatic run_xfer(input int done_at, input bit drop,
                          output int lat, output logic [7:0] byte_v,
                          output int lc, output logic [NREQ-1:0] ack_v,
                          output logic err_v, output logic [NREQ-1:0] ack_nx,
                          output logic err_nx);
    lat = 0;
    while (load !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    byte_v = byteOut;
    lc = 0;
    while (load === 1'b1 && lc < 300) begin
      lc++;
      txDone = (lc == done_at);
      tick();
    end
    txDone = 1'b0;
    ack_v  = ack;
    err_v  = errPulse;
    if (drop) req = req & ~ack;
    tick();
    ack_nx = ack;
    err_nx = errPulse;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (load !== 1'b0)     begin errors++; $display("FAIL rst_load got %b exp 0", load); end
    checks++; if (byteOut !== 8'h00) begin errors++; $display("FAIL rst_byte got %h exp 00", byteOut); end
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL rst_ack got %b exp 0000", ack); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (errPulse !== 1'b0) begin errors++; $display("FAIL rst_errp got %b exp 0", errPulse); end
    checks++; if (errFlag !== 1'b0)  begin errors++; $display("FAIL rst_errf got %b exp 0", errFlag); end
  endtask

  task automatic test_single();
    int lat, lc; logic [7:0] b; logic [NREQ-1:0] a, an; logic e, en;
    apply_reset();
    req = 4'b0001;
    run_xfer(8, 1'b1, lat, b, lc, a, e, an, en);
    checks++; if (lat !== 2)      begin errors++; $display("FAIL single_lat got %0d exp 2", lat); end
    checks++; if (b !== 8'h0B)    begin errors++; $display("FAIL single_byte got %h exp 0b", b); end
    checks++; if (lc !== 8)       begin errors++; $display("FAIL single_loadlen got %0d exp 8", lc); end
    checks++; if (a !== 4'b0001)  begin errors++; $display("FAIL single_ack got %b exp 0001", a); end
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL single_ack_once got %b exp 0000", an); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL single_errp got %b exp 0", e); end
    checks++; if (errFlag !== 1'b0) begin errors++; $display("FAIL single_errf got %b exp 0", errFlag); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    int lat, lc; logic [7:0] b; logic [NREQ-1:0] a, an; logic e, en;
    logic [NREQ-1:0] exp_a [8];
    logic [7:0]      exp_b [8];
    exp_a = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
    exp_b = '{8'h0B,   8'h33,   8'h0B,   8'h33,   8'h0B,   8'h22,   8'h33,   8'h0B};
    apply_reset();
    req = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) req = 4'b0111;
      run_xfer(3, 1'b0, lat, b, lc, a, e, an, en);
      checks++; if (a !== exp_a[i]) begin errors++; $display("FAIL rr_ack[%0d] got %b exp %b", i, a, exp_a[i]); end
      checks++; if (b !== exp_b[i]) begin errors++; $display("FAIL rr_byte[%0d] got %h exp %h", i, b, exp_b[i]); end
      checks++; if (lat !== 2)      begin errors++; $display("FAIL rr_gap[%0d] got %0d exp 2", i, lat); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int lat, lc; logic [7:0] b; logic [NREQ-1:0] a, an; logic e, en;
    apply_reset();
    req = 4'b0010;
    run_xfer(0, 1'b1, lat, b, lc, a, e, an, en);
    checks++; if (lc !== TO)      begin errors++; $display("FAIL to_loadlen got %0d exp %0d", lc, TO); end
    checks++; if (a !== 4'b0010)  begin errors++; $display("FAIL to_ack got %b exp 0010", a); end
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL to_ack_once got %b exp 0000", an); end
    checks++; if (e !== 1'b1)     begin errors++; $display("FAIL to_errp got %b exp 1", e); end
    checks++; if (en !== 1'b0)    begin errors++; $display("FAIL to_errp_once got %b exp 0", en); end
    tick(); tick(); tick();
    checks++; if (errFlag !== 1'b1) begin errors++; $display("FAIL to_errf_sticky got %b exp 1", errFlag); end
  endtask

  task automatic test_done_vs_timeout();
    int lat, lc; logic [7:0] b; logic [NREQ-1:0] a, an; logic e, en;
    apply_reset();
    checks++; if (errFlag !== 1'b0) begin errors++; $display("FAIL dvt_errf_cleared got %b exp 0", errFlag); end
    req = 4'b0001;
    run_xfer(TO, 1'b1, lat, b, lc, a, e, an, en);
    checks++; if (lc !== TO)     begin errors++; $display("FAIL dvt_loadlen got %0d exp %0d", lc, TO); end
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL dvt_ack got %b exp 0001", a); end
    checks++; if (e !== 1'b0)    begin errors++; $display("FAIL dvt_errp got %b exp 0", e); end
    checks++; if (errFlag !== 1'b0) begin errors++; $display("FAIL dvt_errf got %b exp 0", errFlag); end
  endtask

  task automatic test_reset_mid_send();
    int lat, lc; logic [7:0] b; logic [NREQ-1:0] a, an; logic e, en;
    apply_reset();
    req = 4'b0100;
    tick(); tick();
    tick(); tick(); tick(); tick();
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL rms_in_send got %b exp 1", load); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (load !== 1'b0)     begin errors++; $display("FAIL rms_load got %b exp 0", load); end
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL rms_ack got %b exp 0000", ack); end
    checks++; if (errPulse !== 1'b0) begin errors++; $display("FAIL rms_errp got %b exp 0", errPulse); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rms_busy got %b exp 0", busy); end
    req = 4'b0101;
    run_xfer(4, 1'b1, lat, b, lc, a, e, an, en);
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL rms_next_grant got %b exp 0001", a); end
    req = '0;
    tick();
  endtask

  task automatic test_spurious_done();
    apply_reset();
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL sp_idle_busy got %b exp 0", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL sp_idle_ack got %b exp 0000", ack); end
    req = 4'b1000;
    tick();
    checks++; if (busy !== 1'b1 || load !== 1'b0) begin errors++; $display("FAIL sp_setup got busy=%b load=%b exp 1/0", busy, load); end
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
    checks++; if (load !== 1'b1)   begin errors++; $display("FAIL sp_setup_load got %b exp 1", load); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL sp_setup_ack got %b exp 0000", ack); end
    // requester withdraws mid-SEND; the transfer still completes
    req = 4'b0000;
    tick(); tick();
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL sp_hold_load got %b exp 1", load); end
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
    checks++; if (ack !== 4'b1000)    begin errors++; $display("FAIL sp_ack got %b exp 1000", ack); end
    checks++; if (byteOut !== 8'h44)  begin errors++; $display("FAIL sp_byte got %h exp 44", byteOut); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid_send();
    test_spurious_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
